// File: rtl/fp8_to_fixed.sv
// fp8_to_fixed: 2-stage elastic FP8 to signed fixed-point converter
module fp8_to_fixed #(
  parameter int FRAC_W = 7,
  localparam int OUT_W = FRAC_W + 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_fp8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_zero,
  output logic             out_inexact,
  output logic [15:0]      conv_count
);
  localparam int SH = 7 - FRAC_W;
  logic s1_valid, s1_sign, s1_zero, s2_load;
  logic [11:0] s1_mag;
  logic [OUT_W-1:0] t_mag;
  assign s2_load = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign t_mag = OUT_W'(s1_mag >> SH);
  // S1: capture sign, zero flag and full 12-bit magnitude in units of 2^-7
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_mag <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_fp8[7];
        s1_zero <= in_fp8[6:0] == 7'd0;
        s1_mag <= in_fp8[6:0] == 7'd0 ? 12'd0 : {7'd0, 1'b1, in_fp8[3:0]} << in_fp8[6:4];
      end
    end
  // S2: truncate to FRAC_W, apply sign, hold while the consumer stalls
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_zero <= 1'b0;
      out_inexact <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_data <= s1_sign ? -t_mag : t_mag;
      out_zero <= s1_zero;
      out_inexact <= |(s1_mag & ((12'd1 << SH) - 12'd1));
    end else if (out_ready) out_valid <= 1'b0;
  // Count delivered results, wrapping at 2^16
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) conv_count <= '0;
    else if (out_valid && out_ready) conv_count <= conv_count + 16'd1;
endmodule

// File: tb/tb_fp8_to_fixed.sv
// tb_fp8_to_fixed: directed, backpressure, sweep, random and reset checks for fp8_to_fixed
module tb_fp8_to_fixed;
  typedef struct {int d7; logic z; logic i7; int d4; logic i4;} exp_t;
  typedef struct {logic [7:0] fp8; exp_t e;} vec_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
  logic [7:0] in_fp8 = 0;
  logic in_ready, in_ready4, out_valid, out_valid4, out_zero, out_zero4, out_inexact, out_inexact4;
  logic signed [12:0] d7;
  logic signed [9:0] d4;
  logic [15:0] conv_count, conv_count4;
  int tests = 0, fails = 0;
  logic [15:0] exp_cnt = 0;
  exp_t q[$];
  vec_t tbl[11];

  fp8_to_fixed #(.FRAC_W(7)) dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_fp8(in_fp8), .out_valid(out_valid), .out_ready(out_ready), .out_data(d7), .out_zero(out_zero),
    .out_inexact(out_inexact), .conv_count(conv_count));
  fp8_to_fixed #(.FRAC_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_fp8(in_fp8), .out_valid(out_valid4), .out_ready(out_ready), .out_data(d4), .out_zero(out_zero4),
    .out_inexact(out_inexact4), .conv_count(conv_count4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [7:0] v);
    exp_t r;
    int m;
    m = (v[6:0] == 7'd0) ? 0 : (16 + int'(v[3:0])) * (1 << int'(v[6:4]));
    r.d7 = v[7] ? -m : m;
    r.z = v[6:0] == 7'd0;
    r.i7 = 1'b0;
    r.d4 = v[7] ? -(m / 8) : m / 8;
    r.i4 = (m % 8) != 0;
    return r;
  endfunction

  task automatic mon();
    exp_t e;
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out got data=%0d expected no output at %0t", d7, $time);
      end else begin
        e = q.pop_front();
        chk("data7", int'(d7), e.d7);
        chk("zero7", int'(out_zero), int'(e.z));
        chk("inexact7", int'(out_inexact), int'(e.i7));
        chk("data4", int'(d4), e.d4);
        chk("inexact4", int'(out_inexact4), int'(e.i4));
      end
      exp_cnt++;
    end
  endtask

  task automatic cyc_step(output logic acc);
    #1 acc = in_valid && in_ready;
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v, input exp_t e);
    int g;
    logic acc;
    q.push_back(e);
    in_valid = 1;
    in_fp8 = v;
    g = 0;
    do begin
      cyc_step(acc);
      g++;
    end while (!acc && g < 100);
    if (!acc) chk("send_accept", int'(acc), 1);
  endtask

  task automatic drain();
    logic acc;
    in_valid = 0;
    out_ready = 1;
    repeat (4) cyc_step(acc);
  endtask

  initial begin
    logic acc;
    int k, g, n;
    tbl[0]  = '{8'h30, '{128, 1'b0, 1'b0, 16, 1'b0}};
    tbl[1]  = '{8'h44, '{320, 1'b0, 1'b0, 40, 1'b0}};
    tbl[2]  = '{8'hC4, '{-320, 1'b0, 1'b0, -40, 1'b0}};
    tbl[3]  = '{8'h7F, '{3968, 1'b0, 1'b0, 496, 1'b0}};
    tbl[4]  = '{8'h01, '{17, 1'b0, 1'b0, 2, 1'b1}};
    tbl[5]  = '{8'h80, '{0, 1'b1, 1'b0, 0, 1'b0}};
    tbl[6]  = '{8'h4C, '{448, 1'b0, 1'b0, 56, 1'b0}};
    tbl[7]  = '{8'h00, '{0, 1'b1, 1'b0, 0, 1'b0}};
    tbl[8]  = '{8'h0F, '{31, 1'b0, 1'b0, 3, 1'b1}};
    tbl[9]  = '{8'h9A, '{-52, 1'b0, 1'b0, -6, 1'b1}};
    tbl[10] = '{8'h25, '{84, 1'b0, 1'b0, 10, 1'b1}};
    #2;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(d7), 0);
    chk("rst_zero", int'(out_zero), 0);
    chk("rst_inexact", int'(out_inexact), 0);
    chk("rst_count", int'(conv_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].fp8, tbl[i].e);
      if (i == 0) chk("lat_not_yet", int'(out_valid), 0);
      if (i == 1) chk("lat_valid", int'(out_valid), 1);
      if (i == 5) begin
        in_valid = 0;
        cyc_step(acc);
        cyc_step(acc);
        chk("b2b_count", int'(conv_count), 6);
        chk("b2b_idle", int'(out_valid), 0);
      end
    end
    drain();
    chk("dir_count", int'(conv_count), int'(exp_cnt));
    chk("dir_drained", q.size(), 0);
    out_ready = 0;
    in_valid = 1;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      in_fp8 = (k < 2) ? tbl[k].fp8 : 8'hFF;
      cyc_step(acc);
      chk("bp_ready", int'(acc), int'(c < 2));
      if (acc && k < 2) begin
        q.push_back(tbl[k].e);
        k++;
      end
      if (c >= 1) begin
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_hold", int'(d7), 128);
      end
    end
    drain();
    chk("bp_drained", q.size(), 0);
    chk("bp_count", int'(conv_count), int'(exp_cnt));
    out_ready = 0;
    send(tbl[3].fp8, tbl[3].e);
    send(tbl[4].fp8, tbl[4].e);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(d7), 0);
    chk("arst_count", int'(conv_count), 0);
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1 rst_n = 1;
    chk("arst_in_ready", int'(in_ready), 1);
    drain();
    chk("arst_no_emit", int'(out_valid), 0);
    chk("arst_count_after", int'(conv_count), 0);
    for (int i = 0; i < 256; i++) send(8'(i), model(8'(i)));
    drain();
    chk("sweep_count", int'(conv_count), 256);
    chk("sweep_drained", q.size(), 0);
    k = 0;
    g = 0;
    while (k < 1000 && g < 20000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_fp8 = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      cyc_step(acc);
      if (acc) begin
        q.push_back(model(in_fp8));
        k++;
      end
      g++;
    end
    chk("rand_done", k, 1000);
    drain();
    chk("rand_drained", q.size(), 0);
    chk("rand_count", int'(conv_count), int'(exp_cnt));
    n = 65536 - int'(exp_cnt) - 2;
    for (int i = 0; i < n; i++) send(8'(i), model(8'(i)));
    drain();
    chk("wrap_pre", int'(conv_count), 16'hFFFE);
    for (int i = 0; i < 4; i++) send(tbl[i].fp8, tbl[i].e);
    drain();
    chk("wrap_post", int'(conv_count), 2);
    chk("wrap_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
